// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter_pkg
// Description : Shared types and constants for the divided-clock period
//               meter: FSM state encoding, counter width and saturation
//               limit, synchronizer depth and a period-sum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_period_meter_pkg;

    // Width of the high/low cycle counters.
    localparam int CNT_W = 16;

    // Counter value at which a missing edge is declared a timeout.
    localparam logic [CNT_W-1:0] MAX_CNT = 16'hFFFF;

    // Counter reload value used at the start of every measured phase.
    localparam logic [CNT_W-1:0] CNT_ONE = 16'h0001;

    // Number of metastability flops in front of the edge-detect register.
    localparam int SYNC_STAGES = 2;

    // Measurement FSM states; IDLE must encode as zero.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } meas_state_t;

    // Full-precision sum of high and low times; one extra bit, so it
    // never overflows.
    function automatic logic [CNT_W:0] period_sum(
        input logic [CNT_W-1:0] high_cnt,
        input logic [CNT_W-1:0] low_cnt
    );
        return {1'b0, high_cnt} + {1'b0, low_cnt};
    endfunction

endpackage : clk_period_meter_pkg
`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Brings an asynchronous level into the i_clk domain through a
//               flop chain, then registers it once more to find its
//               rising and falling transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det
    import clk_period_meter_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    // Metastability chain; bit 0 is the first flop to see the input.
    logic [SYNC_STAGES-1:0] r_sync_chain;

    // Previous-cycle copy of the synchronized level for edge detection.
    logic                   r_dly;

    logic                   w_sync;

    assign w_sync = r_sync_chain[SYNC_STAGES-1];

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync_chain <= '0;
        end else begin
            r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    // Hold the last synchronized level so transitions can be detected.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dly <= 1'b0;
        end else begin
            r_dly <= w_sync;
        end
    end

    assign o_sync = w_sync;
    assign o_rise =  w_sync & ~r_dly;
    assign o_fall = ~w_sync &  r_dly;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter
// Description : Measures the high and low times of a divided clock in i_clk
//               cycles. A measurement aligns to a rising edge, counts the
//               high phase up to the falling edge, then the low phase up to
//               the next rising edge, and publishes high, low and period
//               with a one-cycle valid pulse. Single-shot or continuous; a
//               phase reaching MAX_CNT without its edge aborts to IDLE with
//               a timeout pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter
    import clk_period_meter_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_div_clk,
    input  logic           i_start,
    input  logic           i_cont,
    output logic [15:0]    o_high_cnt,
    output logic [15:0]    o_low_cnt,
    output logic [16:0]    o_period,
    output logic           o_valid,
    output logic           o_busy,
    output logic           o_timeout
);

    // ------------------------------------------------------------------
    // Edge detection on the measured signal
    // ------------------------------------------------------------------
    logic w_div_sync;
    logic w_rise;
    logic w_fall;

    sync_edge_det u_sync_edge_det (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_div_clk),
        .o_sync    (w_div_sync),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    // ------------------------------------------------------------------
    // State, counter and result registers
    // ------------------------------------------------------------------
    meas_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_high_tmp;
    logic [CNT_W-1:0]   r_high_cnt;
    logic [CNT_W-1:0]   r_low_cnt;
    logic [CNT_W:0]     r_period;
    logic               r_valid;
    logic               r_timeout;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    meas_state_t        w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_high_tmp_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_max;
    logic               w_capture;
    logic               w_timeout;

    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign w_cnt_max = (r_cnt == MAX_CNT);

    // Register the FSM state, phase counter and the pending high time.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_high_tmp <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_high_tmp <= w_high_tmp_nxt;
        end
    end

    // Decide the next state and counter value. A qualifying edge always
    // wins over the timeout, so a phase lasting exactly MAX_CNT cycles
    // still measures; only the cycle after that without an edge aborts.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_high_tmp_nxt = r_high_tmp;
        w_capture      = 1'b0;
        w_timeout      = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = WAIT_RISE;
                    w_cnt_nxt   = CNT_ONE;
                end
            end

            WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = MEAS_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end else if (w_cnt_max) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end

            MEAS_HIGH: begin
                if (w_fall) begin
                    w_state_nxt    = MEAS_LOW;
                    w_high_tmp_nxt = r_cnt;
                    w_cnt_nxt      = CNT_ONE;
                end else if (w_cnt_max) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end

            MEAS_LOW: begin
                if (w_rise) begin
                    // The rising edge that ends this period also starts
                    // the next high phase in continuous mode.
                    w_capture = 1'b1;
                    if (i_cont) begin
                        w_state_nxt = MEAS_HIGH;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_cnt_max) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Publish a finished measurement; results only move on a capture.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
            r_period   <= '0;
        end else if (w_capture) begin
            r_high_cnt <= r_high_tmp;
            r_low_cnt  <= r_cnt;
            r_period   <= period_sum(r_high_tmp, r_cnt);
        end
    end

    // One-cycle status pulses; capture and timeout are mutually exclusive
    // branches of the same case arm, so they never coincide.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid   <= w_capture;
            r_timeout <= w_timeout;
        end
    end

    assign o_high_cnt = r_high_cnt;
    assign o_low_cnt  = r_low_cnt;
    assign o_period   = r_period;
    assign o_valid    = r_valid;
    assign o_timeout  = r_timeout;
    assign o_busy     = (r_state != IDLE);

    // The synchronized level itself is not needed by the FSM, only its
    // edges; keep it visible as a named net for debug.
    logic w_unused;
    assign w_unused = w_div_sync;

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_meter
// Description : Self-checking bench for clk_period_meter. A table of
//               high/low/mode records drives a programmable divided clock;
//               hand-written sequences cover restart, reset and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    logic        i_clk     = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_div_clk = 1'b0;
    logic        i_start   = 1'b0;
    logic        i_cont    = 1'b0;
    logic [15:0] o_high_cnt;
    logic [15:0] o_low_cnt;
    logic [16:0] o_period;
    logic        o_valid;
    logic        o_busy;
    logic        o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    clk_period_meter dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_div_clk  (i_div_clk),
        .i_start    (i_start),
        .i_cont     (i_cont),
        .o_high_cnt (o_high_cnt),
        .o_low_cnt  (o_low_cnt),
        .o_period   (o_period),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Free-running cycle counter for latency and spacing checks.
    int cyc_ctr = 0;
    always @(posedge i_clk) cyc_ctr <= cyc_ctr + 1;

    // Programmable divided-clock generator, synchronous to i_clk.
    bit gen_en = 1'b0;
    int gen_hi = 3;
    int gen_lo = 3;
    int gen_cnt = 0;
    int last_rise_cyc = 0;
    always begin
        @(posedge i_clk);
        #1;
        if (!gen_en) begin
            i_div_clk = 1'b0;
            gen_cnt   = 0;
        end else begin
            gen_cnt++;
            if (i_div_clk && gen_cnt >= gen_hi) begin
                i_div_clk = 1'b0;
                gen_cnt   = 0;
            end else if (!i_div_clk && gen_cnt >= gen_lo) begin
                i_div_clk     = 1'b1;
                gen_cnt       = 0;
                last_rise_cyc = cyc_ctr;
            end
        end
    end

    // Pulse monitors.
    int n_valid   = 0;
    int n_timeout = 0;
    int n_both    = 0;
    always @(negedge i_clk) begin
        if (o_valid)              n_valid++;
        if (o_timeout)            n_timeout++;
        if (o_valid && o_timeout) n_both++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge i_clk);
            if (o_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    typedef struct {
        int          hi;
        int          lo;
        bit          cont;
        int          nval;
        logic [15:0] e_hi;
        logic [15:0] e_lo;
        logic [16:0] e_per;
    } vec_t;

    vec_t vt[5];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int prev_cyc;
        int total;
        int v0;
        int t0;
        int cyc;
        bit busy_seen;

        vt[0] = '{hi: 3,  lo: 3, cont: 1'b0, nval: 1, e_hi: 16'd3,  e_lo: 16'd3, e_per: 17'd6};
        vt[1] = '{hi: 5,  lo: 2, cont: 1'b1, nval: 3, e_hi: 16'd5,  e_lo: 16'd2, e_per: 17'd7};
        vt[2] = '{hi: 4,  lo: 7, cont: 1'b0, nval: 1, e_hi: 16'd4,  e_lo: 16'd7, e_per: 17'd11};
        vt[3] = '{hi: 10, lo: 1, cont: 1'b0, nval: 1, e_hi: 16'd10, e_lo: 16'd1, e_per: 17'd11};
        vt[4] = '{hi: 2,  lo: 2, cont: 1'b1, nval: 2, e_hi: 16'd2,  e_lo: 16'd2, e_per: 17'd4};

        // Reset state.
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_high", o_high_cnt, 0);
        chk("reset_low", o_low_cnt, 0);
        chk("reset_period", o_period, 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_timeout", o_timeout, 0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("idle_busy", o_busy, 0);

        // Table-driven measurements.
        for (int v = 0; v < 5; v++) begin
            gen_en = 1'b0;
            i_cont = vt[v].cont;
            repeat (10) @(posedge i_clk);
            #1;
            gen_hi = vt[v].hi;
            gen_lo = vt[v].lo;
            gen_en = 1'b1;
            v0     = n_valid;
            total  = vt[v].nval + (vt[v].cont ? 1 : 0);
            pulse_start();
            prev_cyc = 0;
            for (int p = 0; p < total; p++) begin
                wait_valid(100, ok);
                chk($sformatf("v%0d_p%0d_valid_seen", v, p), ok, 1);
                chk($sformatf("v%0d_p%0d_high", v, p), o_high_cnt, vt[v].e_hi);
                chk($sformatf("v%0d_p%0d_low", v, p), o_low_cnt, vt[v].e_lo);
                chk($sformatf("v%0d_p%0d_period", v, p), o_period, vt[v].e_per);
                chk($sformatf("v%0d_p%0d_latency", v, p), cyc_ctr - last_rise_cyc, 3);
                chk($sformatf("v%0d_p%0d_busy", v, p), o_busy, (vt[v].cont && p < vt[v].nval) ? 1 : 0);
                if (p > 0)
                    chk($sformatf("v%0d_p%0d_spacing", v, p), cyc_ctr - prev_cyc, vt[v].hi + vt[v].lo);
                prev_cyc = cyc_ctr;
                if (vt[v].cont && p == vt[v].nval - 1)
                    i_cont = 1'b0;
            end
            repeat (3 * (vt[v].hi + vt[v].lo)) @(negedge i_clk);
            chk($sformatf("v%0d_busy_after", v), o_busy, 0);
            chk($sformatf("v%0d_valid_count", v), n_valid - v0, total);
        end

        // Re-pulsed start while busy is ignored.
        gen_en = 1'b0;
        i_cont = 1'b0;
        repeat (10) @(posedge i_clk);
        #1;
        gen_hi = 3;
        gen_lo = 3;
        gen_en = 1'b1;
        v0 = n_valid;
        pulse_start();
        repeat (2) @(posedge i_clk);
        #1;
        chk("restart_busy", o_busy, 1);
        pulse_start();
        repeat (2) @(posedge i_clk);
        #1;
        pulse_start();
        wait_valid(100, ok);
        chk("restart_valid_seen", ok, 1);
        chk("restart_high", o_high_cnt, 3);
        chk("restart_low", o_low_cnt, 3);
        chk("restart_period", o_period, 6);
        repeat (40) @(negedge i_clk);
        chk("restart_valid_count", n_valid - v0, 1);
        chk("restart_busy_after", o_busy, 0);

        // Reset pulsed during MEAS_LOW of a continuous run.
        i_cont = 1'b1;
        @(posedge i_clk);
        #1;
        pulse_start();
        wait_valid(100, ok);
        chk("rst_first_valid_seen", ok, 1);
        repeat (4) @(posedge i_clk);
        #2;
        v0 = n_valid;
        t0 = n_timeout;
        i_reset_n = 1'b0;
        #1;
        chk("rst_high_zero", o_high_cnt, 0);
        chk("rst_low_zero", o_low_cnt, 0);
        chk("rst_period_zero", o_period, 0);
        chk("rst_busy_zero", o_busy, 0);
        chk("rst_valid_zero", o_valid, 0);
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        i_cont    = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            if (o_busy) busy_seen = 1'b1;
        end
        chk("rst_busy_stays_low", busy_seen, 0);
        chk("rst_no_valid", n_valid - v0, 0);
        chk("rst_no_timeout", n_timeout - t0, 0);
        pulse_start();
        wait_valid(100, ok);
        chk("rst_new_valid_seen", ok, 1);
        chk("rst_new_high", o_high_cnt, 3);
        chk("rst_new_low", o_low_cnt, 3);
        chk("rst_new_period", o_period, 6);

        // Timeout with the measured signal held low.
        gen_en = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        v0 = n_valid;
        t0 = n_timeout;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        cyc = 0;
        while (!o_timeout && cyc < 70000) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        chk("to_seen", o_timeout, 1);
        chk("to_cycles", cyc, 65535);
        chk("to_busy", o_busy, 0);
        chk("to_high", o_high_cnt, 0);
        chk("to_low", o_low_cnt, 0);
        chk("to_period", o_period, 0);
        @(posedge i_clk);
        #1;
        chk("to_one_cycle", o_timeout, 0);
        chk("to_timeout_count", n_timeout - t0, 1);
        chk("to_no_valid", n_valid - v0, 0);

        chk("valid_timeout_exclusive", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_clk_period_meter
`default_nettype wire

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single system clock, rising-edge active.
REQ-002 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port i_div_clk, input, 1 bit: divided-clock signal under measurement; not used as a clock.
REQ-004 SHALL have port i_start, input, 1 bit: start request, sampled each i_clk cycle.
REQ-005 SHALL have port i_cont, input, 1 bit: 1 = continuous measurement, 0 = single-shot; sampled only when a measurement completes.
REQ-006 SHALL have port o_high_cnt, output, 16 bits: last measured high time, in i_clk cycles.
REQ-007 SHALL have port o_low_cnt, output, 16 bits: last measured low time, in i_clk cycles.
REQ-008 SHALL have port o_period, output, 17 bits: o_high_cnt + o_low_cnt.
REQ-009 SHALL have port o_valid, output, 1 bit: one-cycle pulse when new results are present.
REQ-010 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port o_timeout, output, 1 bit: one-cycle pulse on edge timeout.

Function
REQ-012 SHALL pass i_div_clk through a 2-flop synchronizer followed by one delay flop; rise = sync & ~dly, fall = ~sync & dly.
REQ-013 SHALL implement states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, held in one state register.
REQ-014 IDLE: i_start=1 -> WAIT_RISE, cnt <= 1; otherwise hold.
REQ-015 WAIT_RISE: rise -> MEAS_HIGH, cnt <= 1; otherwise cnt <= cnt+1.
REQ-016 MEAS_HIGH: fall -> capture high_tmp <= cnt, cnt <= 1, go to MEAS_LOW; otherwise cnt <= cnt+1.
REQ-017 MEAS_LOW on rise: register o_high_cnt <= high_tmp, o_low_cnt <= cnt, o_period <= high_tmp+cnt (17-bit, no overflow), and o_valid <= 1 for one cycle.
REQ-018 After that capture, SHALL go to MEAS_HIGH with cnt <= 1 if i_cont=1, else to IDLE; otherwise cnt <= cnt+1.
REQ-019 In a non-IDLE state, cnt == MAX_CNT with no qualifying edge -> o_timeout pulse one cycle, go to IDLE, result outputs unchanged.
REQ-020 i_start while o_busy=1 SHALL be ignored.
REQ-021 Continuous mode SHALL be left only by completion with i_cont=0, by timeout, or by reset.
REQ-022 o_valid and o_timeout SHALL never be asserted in the same cycle.
REQ-023 Result outputs SHALL change only in the cycle o_valid asserts.
REQ-024 o_valid SHALL rise 3 i_clk cycles after the i_div_clk rising transition that ends the period (2 sync + 1 edge register).

Reset
REQ-025 i_reset_n=0 SHALL asynchronously force: state IDLE, cnt 0, high_tmp 0, sync/delay flops 0, all outputs 0.
REQ-026 Reset asserted mid-measurement SHALL abort without o_valid or o_timeout; after release, o_busy SHALL stay 0 until i_start.

Structure
REQ-027 A shared package SHALL hold the state encoding (2-bit, IDLE=0), CNT_W=16 and MAX_CNT=16'hFFFF.
REQ-028 The synchronizer plus edge detector SHALL be one sub-module, sync_edge_det (outputs: sync level, rise, fall).
REQ-029 The FSM, counter and result registers SHALL stay in clk_period_meter.

Verification
REQ-030 i_div_clk = i_clk/6 (3 high, 3 low), i_start pulse, i_cont=0 -> one o_valid with high=3, low=3, period=6, then o_busy=0.
REQ-031 Asymmetric input (5 high, 2 low), i_cont=1 -> o_valid once per input period, each with 5/2/7, o_busy held 1.
REQ-032 i_div_clk held 0, i_start -> o_timeout pulse once cnt reaches MAX_CNT (65535 cycles after start), outputs stay 0, return to IDLE.
REQ-033 i_start re-pulsed during MEAS_HIGH -> no restart; measurement result matches the first run.
REQ-034 i_reset_n pulsed low during MEAS_LOW -> all outputs 0 immediately; no o_valid; new i_start gives a correct 3/3/6 result.
REQ-035 Continuous run, i_cont dropped mid-period -> the current period completes with o_valid, then IDLE.
